// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forwarding-select encodings and the hardwired-zero register.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer writing dst collides with a consumer actually reading src.
  function automatic logic src_hit(input logic [4:0] src, input logic use_src,
                                   input logic [4:0] dst, input logic wr);
    return use_src && wr && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Per-operand ALU forwarding select; the youngest producer (EX/MEM) wins.
// Built only when HAZARD_FWD_EN is defined.
`ifdef HAZARD_FWD_EN
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       exmem_regwr_i,
  input  logic [4:0] memwb_rd_i,
  input  logic       memwb_regwr_i,
  output logic [1:0] fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (src_i != REG_ZERO) begin
      if (exmem_regwr_i && (exmem_rd_i == src_i))      fwd_sel_o = FWD_EXMEM;
      else if (memwb_regwr_i && (memwb_rd_i == src_i)) fwd_sel_o = FWD_MEMWB;
    end
  end

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing: stage enables/flushes, forwarding selects
// and data-memory request. Optional forwarding path under HAZARD_FWD_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       idex_rd,
  input  logic             idex_regwr,
  input  logic             idex_memrd,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwr,
  input  logic             exmem_memacc,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwr,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_req,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               haz, mem_hold, stall_inc;
  logic [1:0][1:0]    fwd_sel;

`ifdef HAZARD_FWD_EN
  logic [1:0][4:0] ex_src;
  logic            unused_regwr;

  assign ex_src       = {ex_rt, ex_rs};
  assign unused_regwr = idex_regwr;

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_unit u_fwd (
      .src_i         (ex_src[g]),
      .exmem_rd_i    (exmem_rd),
      .exmem_regwr_i (exmem_regwr),
      .memwb_rd_i    (memwb_rd),
      .memwb_regwr_i (memwb_regwr),
      .fwd_sel_o     (fwd_sel[g])
    );
  end

  // Only a load in EX needs a bubble; everything else is forwarded.
  assign haz = src_hit(id_rs, id_use_rs, idex_rd, idex_memrd)
             | src_hit(id_rt, id_use_rt, idex_rd, idex_memrd);
`else
  logic unused_ex_src;

  assign unused_ex_src = ^{ex_rs, ex_rt};
  assign fwd_sel       = '0;

  // Without forwarding, ID waits until no in-flight producer matches.
  assign haz = src_hit(id_rs, id_use_rs, idex_rd,  idex_regwr)
             | src_hit(id_rt, id_use_rt, idex_rd,  idex_regwr)
             | src_hit(id_rs, id_use_rs, exmem_rd, exmem_regwr)
             | src_hit(id_rt, id_use_rt, exmem_rd, exmem_regwr)
             | src_hit(id_rs, id_use_rs, memwb_rd, memwb_regwr)
             | src_hit(id_rt, id_use_rt, memwb_rd, memwb_regwr);
`endif

  // Inside MEM_WAIT the access is already outstanding, so only the ack matters.
  assign mem_hold = (state_q == ST_MEM_WAIT) ? !mem_ack : (exmem_memacc && !mem_ack);

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_req     = exmem_memacc;
    fwd_a       = fwd_sel[0];
    fwd_b       = fwd_sel[1];
    case (state_q)
      ST_ERROR: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        mem_req  = 1'b0;
      end
      default: begin
        if (state_q == ST_MEM_WAIT) mem_req = 1'b1;
        if (mem_hold) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          mem_req     = 1'b1;
          if (state_q != ST_MEM_WAIT) begin
            state_d = ST_MEM_WAIT;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_W'(MEM_TIMEOUT)) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          end
        end else if (state_q == ST_LU_STALL) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (haz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
`ifdef HAZARD_FWD_EN
            state_d    = ST_LU_STALL;
`endif
          end
        end
      end
    endcase
    if (!rst) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      mem_req     = 1'b0;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end
  end

  assign stall_inc = !pc_en && (state_q != ST_ERROR) && (stall_cnt_q != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random
// traffic, checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 15;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int M_RUN = 0, M_LU = 1, M_WAIT = 2, M_ERR = 3;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_rs, id_rt;
    logic       id_use_rs, id_use_rt;
    logic [4:0] ex_rs, ex_rt, idex_rd;
    logic       idex_regwr, idex_memrd;
    logic [4:0] exmem_rd;
    logic       exmem_regwr, exmem_memacc;
    logic [4:0] memwb_rd;
    logic       memwb_regwr, branch_taken, mem_ack;
  } in_t;

  typedef struct packed {
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic mem_req, err;
    logic [CW-1:0] stall_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rs = '0, ex_rt = '0, idex_rd = '0, exmem_rd = '0, memwb_rd = '0;
  logic id_use_rs = 0, id_use_rt = 0, idex_regwr = 0, idex_memrd = 0, exmem_regwr = 0;
  logic exmem_memacc = 0, memwb_regwr = 0, branch_taken = 0, mem_ack = 1;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic mem_req, err;
  logic [CW-1:0] stall_cnt;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  int m_st = M_RUN;
  int m_wait = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .idex_rd(idex_rd), .idex_regwr(idex_regwr),
    .idex_memrd(idex_memrd), .exmem_rd(exmem_rd), .exmem_regwr(exmem_regwr),
    .exmem_memacc(exmem_memacc), .memwb_rd(memwb_rd), .memwb_regwr(memwb_regwr),
    .branch_taken(branch_taken), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_req(mem_req),
    .err(err), .stall_cnt(stall_cnt)
  );

  function automatic in_t idle();
    in_t s;
    s = '0;
    s.rst = 1'b1;
    s.mem_ack = 1'b1;
    return s;
  endfunction

  // Does the ID instruction read register r (r0 never counts)?
  function automatic bit reads(input in_t s, input logic [4:0] r);
    return (r != 5'd0) && ((s.id_use_rs && s.id_rs == r) || (s.id_use_rt && s.id_rt == r));
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_ref(input in_t s, input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (s.exmem_regwr && s.exmem_rd == src) return 2'b10;
    if (s.memwb_regwr && s.memwb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit hazard(input in_t s);
    return s.idex_memrd && reads(s, s.idex_rd);
  endfunction
`else
  function automatic bit hazard(input in_t s);
    return (s.idex_regwr && reads(s, s.idex_rd)) ||
           (s.exmem_regwr && reads(s, s.exmem_rd)) ||
           (s.memwb_regwr && reads(s, s.memwb_rd));
  endfunction
`endif

  // Expected outputs for this cycle; advances the model to the next cycle.
  function automatic exp_t model(input in_t s);
    exp_t e;
    bit frozen;
    e = '0;
    {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = 5'b11111;
    e.err = m_err;
    e.stall_cnt = CW'(m_cnt);
    e.mem_req = s.exmem_memacc;
`ifdef HAZARD_FWD_EN
    e.fwd_a = fwd_ref(s, s.ex_rs);
    e.fwd_b = fwd_ref(s, s.ex_rt);
`endif
    if (!s.rst) begin
      e.fwd_a = 2'b00;
      e.fwd_b = 2'b00;
      e.mem_req = 1'b0;
      m_st = M_RUN; m_wait = 0; m_err = 1'b0; m_cnt = 0;
      return e;
    end
    if (m_st == M_ERR) begin
      {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en, e.memwb_en} = 5'b00000;
      e.mem_req = 1'b0;
      return e;
    end
    frozen = (m_st == M_WAIT) ? !s.mem_ack : (s.exmem_memacc && !s.mem_ack);
    if (m_st == M_WAIT) e.mem_req = 1'b1;
    if (frozen) begin
      {e.pc_en, e.ifid_en, e.idex_en, e.exmem_en} = 4'b0000;
      e.memwb_flush = 1'b1;
      e.mem_req = 1'b1;
      if (m_st == M_WAIT) begin
        m_wait++;
        if (m_wait >= TMO) begin m_st = M_ERR; m_err = 1'b1; end
      end else begin
        m_st = M_WAIT; m_wait = 0;
      end
    end else if (m_st == M_LU) begin
      m_st = M_RUN;
    end else begin
      m_st = M_RUN;
      if (s.branch_taken) begin
        e.ifid_flush = 1'b1;
        e.idex_flush = 1'b1;
      end else if (hazard(s)) begin
        e.pc_en = 1'b0;
        e.ifid_en = 1'b0;
        e.idex_flush = 1'b1;
`ifdef HAZARD_FWD_EN
        m_st = M_LU;
`endif
      end
    end
    if (!e.pc_en && m_cnt < CNT_MAX) m_cnt++;
    return e;
  endfunction

  task automatic step(input in_t s, input string tag);
    @(posedge clk); #1;
    rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt;
    id_use_rs = s.id_use_rs; id_use_rt = s.id_use_rt;
    ex_rs = s.ex_rs; ex_rt = s.ex_rt; idex_rd = s.idex_rd;
    idex_regwr = s.idex_regwr; idex_memrd = s.idex_memrd;
    exmem_rd = s.exmem_rd; exmem_regwr = s.exmem_regwr; exmem_memacc = s.exmem_memacc;
    memwb_rd = s.memwb_rd; memwb_regwr = s.memwb_regwr;
    branch_taken = s.branch_taken; mem_ack = s.mem_ack;
    exp_q.push_back(model(s));
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e, a;
    string tag;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tag = tag_q.pop_front();
      a = '0;
      a.pc_en = pc_en; a.ifid_en = ifid_en; a.idex_en = idex_en;
      a.exmem_en = exmem_en; a.memwb_en = memwb_en;
      a.ifid_flush = ifid_flush; a.idex_flush = idex_flush; a.memwb_flush = memwb_flush;
      a.fwd_a = fwd_a; a.fwd_b = fwd_b; a.mem_req = mem_req; a.err = err;
      a.stall_cnt = stall_cnt;
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %b expected %b (en5,fl3,fa,fb,req,err,cnt)", tag, $time, a, e);
      end
    end
  end

  initial begin
    in_t s, r;
    r = idle();
    r.rst = 1'b0;

    // Reset state
    step(r, "reset");
    step(idle(), "idle");

    // Load-use: lw r5 in EX, add reads r5 in ID
    s = idle(); s.idex_memrd = 1; s.idex_regwr = 1; s.idex_rd = 5;
    s.id_rs = 5; s.id_use_rs = 1;
    step(s, "lu_detect");
    s = idle(); s.exmem_rd = 5; s.exmem_regwr = 1; s.exmem_memacc = 1;
    s.id_rs = 5; s.id_use_rs = 1;
    step(s, "lu_bubble");
    s = idle(); s.memwb_rd = 5; s.memwb_regwr = 1; s.ex_rs = 5;
    step(s, "lu_fwd_memwb");

    // EX/EX forwarding on rt, then r0 destination
    step(r, "reset2");
    s = idle(); s.exmem_rd = 3; s.exmem_regwr = 1; s.ex_rt = 3; s.ex_rs = 7;
    step(s, "fwd_exmem_b");
    s = idle(); s.exmem_rd = 0; s.exmem_regwr = 1; s.ex_rt = 0;
    step(s, "fwd_r0");
    s = idle(); s.exmem_rd = 4; s.exmem_regwr = 1; s.memwb_rd = 4; s.memwb_regwr = 1;
    s.ex_rs = 4; s.ex_rt = 4;
    step(s, "fwd_priority");

    // Branch taken with a load-use candidate in ID
    s = idle(); s.branch_taken = 1; s.idex_memrd = 1; s.idex_regwr = 1; s.idex_rd = 6;
    s.id_rt = 6; s.id_use_rt = 1;
    step(s, "branch_lu");
    step(idle(), "after_branch");

    // Memory wait: ack low 3 cycles, then ack
    step(r, "reset3");
    s = idle(); s.exmem_memacc = 1; s.mem_ack = 0;
    repeat (3) step(s, "mem_wait");
    s.mem_ack = 1;
    step(s, "mem_ack");
    step(idle(), "mem_resume");

    // Timeout into ERROR, then a reset pulse
    s = idle(); s.exmem_memacc = 1; s.mem_ack = 0;
    repeat (20) step(s, "timeout");
    s.branch_taken = 1; s.mem_ack = 1;
    step(s, "error_hold");
    step(r, "err_reset");
    step(idle(), "err_cleared");

    // Back-to-back dependent adds on r2 travelling EX -> MEM -> WB
    step(r, "reset4");
    s = idle(); s.id_rs = 2; s.id_use_rs = 1; s.idex_rd = 2; s.idex_regwr = 1;
    step(s, "dep_ex");
    s = idle(); s.id_rs = 2; s.id_use_rs = 1; s.exmem_rd = 2; s.exmem_regwr = 1;
    step(s, "dep_mem");
    s = idle(); s.id_rs = 2; s.id_use_rs = 1; s.memwb_rd = 2; s.memwb_regwr = 1;
    step(s, "dep_wb");
    s = idle(); s.id_rs = 2; s.id_use_rs = 1;
    step(s, "dep_clear");

    // Random traffic over a small register window to provoke matches
    repeat (800) begin
      s = idle();
      s.rst = ($urandom_range(0, 63) != 0);
      s.id_rs = 5'($urandom_range(0, 3)); s.id_rt = 5'($urandom_range(0, 3));
      s.id_use_rs = 1'($urandom); s.id_use_rt = 1'($urandom);
      s.ex_rs = 5'($urandom_range(0, 3)); s.ex_rt = 5'($urandom_range(0, 3));
      s.idex_rd = 5'($urandom_range(0, 3));
      s.idex_regwr = 1'($urandom); s.idex_memrd = ($urandom_range(0, 2) == 0);
      s.exmem_rd = 5'($urandom_range(0, 3)); s.exmem_regwr = 1'($urandom);
      s.exmem_memacc = ($urandom_range(0, 2) == 0);
      s.memwb_rd = 5'($urandom_range(0, 3)); s.memwb_regwr = 1'($urandom);
      s.branch_taken = ($urandom_range(0, 7) == 0);
      s.mem_ack = ($urandom_range(0, 3) != 0);
      step(s, "random");
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
